// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: drains a programmed word count
// through the 1-cycle-latency read port and re-presents it as a valid/ready stream.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
endpackage

module fifo_stream_reader #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_abort,
  output logic                  o_fifo_rd,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_data_valid,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_last,
  input  logic                  i_m_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [LEN_WIDTH-1:0]  o_words_left
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]           BUF_LAST = 2'd2;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == BUF_LAST) ? 2'd0 : ptr + 2'd1;
  endfunction

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_issue_left;
  logic [LEN_WIDTH-1:0]  r_words_left;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [0:2];
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_count;

  logic       w_run;
  logic       w_active;
  logic       w_start;
  logic       w_abort;
  logic       w_push;
  logic       w_pop;
  logic       w_fifo_rd;
  logic       w_last_hs;
  logic [2:0] w_occupancy;

  assign w_run       = (r_state == S_RUN);
  assign w_active    = w_run || (r_state == S_DRAIN);
  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_abort     = w_active && i_abort;
  // Reads in flight count against buffer space so a full buffer never sees read data.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_fifo_rd   = w_run && !i_abort && (r_issue_left != '0) && !i_fifo_empty
                       && (w_occupancy < 3'd3);
  assign w_push      = w_active && i_fifo_data_valid;
  assign w_pop       = (r_count != 2'd0) && i_m_ready;
  assign w_last_hs   = w_pop && (r_words_left == LEN_ONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_len == '0) ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_ABORT;
        end else if (w_fifo_rd && (r_issue_left == LEN_ONE)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          w_state_nxt = S_ABORT;
        end else if (w_last_hs) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_issue_left <= '0;
      r_words_left <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_fifo_rd;
      if (w_start) begin
        r_issue_left <= i_len;
        r_words_left <= i_len;
      end else if (w_abort) begin
        r_issue_left <= '0;
        r_words_left <= '0;
      end else begin
        if (w_fifo_rd) begin
          r_issue_left <= r_issue_left - LEN_ONE;
        end
        if (w_pop && (r_words_left != '0)) begin
          r_words_left <= r_words_left - LEN_ONE;
        end
      end
    end
  end

  // Three-entry ring absorbing downstream backpressure; head is always the presented word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_abort) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= i_fifo_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_fifo_rd    = w_fifo_rd;
  assign o_m_valid    = (r_count != 2'd0);
  assign o_m_data     = r_buf[r_rd_ptr];
  assign o_m_last     = o_m_valid && (r_words_left == LEN_ONE);
  assign o_busy       = w_active || (r_state == S_ABORT);
  assign o_done       = (r_state == S_DONE);
  assign o_words_left = r_words_left;

endmodule
